mem_stream_bridge: RTL and testbench
====================================

Name: mem_stream_bridge

Overview:
- Memory-side stage that sits directly upstream/downstream of the kernel wrapper and serves its read and write streams.
- Backs a word RAM of 2^ADDR_WID words, answers read_enable/finish_read and write_enable/finish_write handshakes with programmable latency, and lets the bench preload and inspect contents.
- Counts the words transferred and the cycles from the first read request to the wrapper's done pulse, for performance reporting.

Parameters:
- ADDR_WID, 14: log2 of RAM depth in words.
- DATA_WID, 32: word width.
- BASE_ADDR, 64'h0: byte address of word 0.
- READ_LAT, 2: cycles from request sample to read_ready; legal range 1..15.
- WRITE_LAT, 2: cycles from request sample to write_ready; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- read_enable  in  1  read stream active.
- read_addr  in  64  byte address of the requested word.
- finish_read  in  1  one-cycle ack; new read_addr is valid in the same cycle.
- read_ready  out  64  value 0 or 1; one-cycle pulse with read_data.
- read_data  out  DATA_WID  word returned.
- write_enable  in  1  write stream active.
- write_addr  in  64  byte address to write.
- write_data  in  DATA_WID  word to write.
- finish_write  in  1  one-cycle ack; new write_addr/write_data are valid in the same cycle.
- write_ready  out  64  value 0 or 1; one-cycle pulse meaning the word was committed.
- done  in  1  kernel-wrapper completion pulse.
- load_en  in  1  bench preload/peek strobe.
- load_we  in  1  1 = write load_data, 0 = peek.
- load_idx  in  ADDR_WID  word index.
- load_data  in  DATA_WID  preload data.
- peek_data  out  DATA_WID  RAM word, valid 1 cycle after a peek.
- rd_words  out  32  words returned since reset.
- wr_words  out  32  words committed since reset.
- perf_cycles  out  64  cycles from first read_enable sample to done.
- addr_err  out  1  sticky flag: an out-of-range access occurred.

Behaviour:
- Reset (asynchronous, reset=0) clears:
  - all outputs to 0;
  - both channels to IDLE;
  - latency counters and the perf counter/armed flag.
  - RAM contents are not cleared.
- Address mapping: index = (addr - BASE_ADDR) >> 2. An address is out of range if addr < BASE_ADDR, addr[1:0] != 0, or index >= 2^ADDR_WID.
  - Out-of-range read returns 0 and sets addr_err.
  - Out-of-range write is dropped but still acknowledged, and sets addr_err.
- Read channel, states R_IDLE, R_WAIT, R_ACK, R_HOLD:
  - R_IDLE: read_enable=1 at edge t → latch read_addr, cnt = READ_LAT-1, go to R_WAIT.
  - R_WAIT: when cnt==0 and the RAM port is granted → register read_data, read_ready=1, go to R_ACK; otherwise decrement cnt, saturating at 0. With no contention, read_ready is visible READ_LAT cycles after edge t.
  - R_ACK: read_ready=0, go to R_HOLD.
  - R_HOLD: finish_read=1 → latch the new read_addr, reload cnt, go to R_WAIT. Else read_enable=0 → R_IDLE. Else stay.
  - read_enable dropping in R_WAIT aborts to R_IDLE with no pulse.
- Write channel, states W_IDLE, W_WAIT, W_ACK, W_HOLD:
  - Mirrors the read channel.
  - Address and data are latched at the request/finish_write edge.
  - The RAM is written in the W_WAIT→W_ACK cycle; write_ready pulses for one cycle.
- Single RAM port arbitration, priority load > read > write:
  - A loser keeps cnt at 0 and retries the next cycle.
  - A peek returns the RAM word one cycle later on peek_data.
- Counters:
  - rd_words increments on each read_ready pulse; wr_words on each write_ready pulse.
  - Both wrap modulo 2^32.
- perf_cycles:
  - Arms on the first R_IDLE→R_WAIT after reset.
  - Increments every cycle while armed.
  - Freezes on a done pulse; a later done has no effect until reset.
- Read and write channels may be active in the same cycle; the result is defined entirely by the arbitration above.

Decomposition:
- Shared package holds:
  - channel state encodings (IDLE=0, WAIT=1, ACK=2, HOLD=3);
  - the ADDR_WID/DATA_WID defaults;
  - an addr_to_index function returning index plus an out-of-range bit.
- One sub-module, mem_chan_fsm: a handshake FSM parameterized by latency, instantiated once for read and once for write; it exposes req, grant and pulse.
- The RAM and arbiter stay in the top level.

Test Plan:
- Read latency: preload idx 0..3 = 10,11,12,13; read_enable with read_addr=BASE and READ_LAT=2 → read_ready at +2 cycles with data 10; each finish_read with addr+4 → 11, 12, 13; then read_enable=0 → R_IDLE, rd_words=4.
- Write commit: write 0xA5 at BASE+8 with WRITE_LAT=3 → write_ready 3 cycles after sampling; a peek of idx 2 returns 0xA5; wr_words=1.
- Contention: read and write both reach cnt 0 in the same cycle → read_ready first, write_ready exactly one cycle later; a simultaneous load_en delays both by one cycle.
- Out-of-range: read at BASE+2^16 → data 0, read_ready still pulses, addr_err=1; write at BASE+1 → RAM unchanged, write_ready pulses.
- Abort and reset: drop read_enable in R_WAIT → no read_ready pulse; assert reset mid-write → all outputs 0 immediately, RAM unchanged at the target word.
- Perf counter: first read_enable, then done pulse 100 cycles later → perf_cycles=100, unchanged by a second done.

Source files
------------

// File: rtl/mem_stream_bridge_pkg.sv
// Shared types and helpers for the memory-side stream bridge.
// Holds channel state encodings, width defaults and byte-address to word-index mapping.
package mem_stream_bridge_pkg;

  localparam int unsigned DefAddrWid = 14;
  localparam int unsigned DefDataWid = 32;

  typedef enum logic [1:0] {
    ChIdle = 2'd0,
    ChWait = 2'd1,
    ChAck  = 2'd2,
    ChHold = 2'd3
  } chan_state_e;

  typedef struct packed {
    logic        oor;
    logic [63:0] idx;
  } addr_map_t;

  function automatic addr_map_t addr_to_index(input logic [63:0] addr, input logic [63:0] base,
                                              input int unsigned addr_wid);
    addr_map_t m;
    m.idx = (addr - base) >> 2;
    m.oor = (addr < base) || (addr[1:0] != 2'b00) || ((m.idx >> addr_wid) != 64'd0);
    return m;
  endfunction

endpackage

// File: rtl/mem_chan_fsm.sv
// Request/acknowledge handshake FSM for one stream channel with a fixed service latency.
// req asks for the shared RAM port; grant commits the access and fires a one-cycle pulse.
module mem_chan_fsm
  import mem_stream_bridge_pkg::*;
#(
  parameter int unsigned Lat = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic finish,
  input  logic grant,
  output logic req,
  output logic capture,
  output logic pulse
);

  localparam logic [3:0] Reload = 4'(Lat - 1);

  chan_state_e state_q;
  logic [3:0]  cnt_q;
  logic        pulse_q;

  // capture tells the owner to latch the request payload this cycle
  assign capture = ((state_q == ChIdle) && enable) || ((state_q == ChHold) && finish);
  assign req     = (state_q == ChWait) && enable && (cnt_q == 4'd0);
  assign pulse   = pulse_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ChIdle;
      cnt_q   <= 4'd0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ChIdle: begin
          if (enable) begin
            cnt_q   <= Reload;
            state_q <= ChWait;
          end
        end
        ChWait: begin
          if (!enable) begin
            state_q <= ChIdle;
          end else if (grant) begin
            pulse_q <= 1'b1;
            state_q <= ChAck;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ChAck: state_q <= ChHold;
        ChHold: begin
          if (finish) begin
            cnt_q   <= Reload;
            state_q <= ChWait;
          end else if (!enable) begin
            state_q <= ChIdle;
          end
        end
        default: state_q <= ChIdle;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_bridge.sv
// Word RAM serving the kernel wrapper's read and write streams over one shared port,
// with bench preload/peek access and transfer/performance counters.
module mem_stream_bridge
  import mem_stream_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WID  = DefAddrWid,
  parameter int unsigned DATA_WID  = DefDataWid,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_enable,
  input  logic [63:0]         read_addr,
  input  logic                finish_read,
  output logic [63:0]         read_ready,
  output logic [DATA_WID-1:0] read_data,
  input  logic                write_enable,
  input  logic [63:0]         write_addr,
  input  logic [DATA_WID-1:0] write_data,
  input  logic                finish_write,
  output logic [63:0]         write_ready,
  input  logic                done,
  input  logic                load_en,
  input  logic                load_we,
  input  logic [ADDR_WID-1:0] load_idx,
  input  logic [DATA_WID-1:0] load_data,
  output logic [DATA_WID-1:0] peek_data,
  output logic [31:0]         rd_words,
  output logic [31:0]         wr_words,
  output logic [63:0]         perf_cycles,
  output logic                addr_err
);

  logic                rd_req, rd_grant, rd_capture, rd_pulse;
  logic                wr_req, wr_grant, wr_capture, wr_pulse;
  logic [63:0]         rd_addr_q, wr_addr_q;
  logic [DATA_WID-1:0] wr_data_q, read_data_q, peek_data_q;
  logic [31:0]         rd_words_q, wr_words_q;
  logic [63:0]         perf_q;
  logic                armed_q, frozen_q, addr_err_q;
  addr_map_t           rd_map, wr_map;
  logic [ADDR_WID-1:0] rd_idx, wr_idx;

  logic [DATA_WID-1:0] mem_q [2**ADDR_WID];

  mem_chan_fsm #(.Lat(READ_LAT)) u_rd_fsm (
    .clk    (clk),
    .reset  (reset),
    .enable (read_enable),
    .finish (finish_read),
    .grant  (rd_grant),
    .req    (rd_req),
    .capture(rd_capture),
    .pulse  (rd_pulse)
  );

  mem_chan_fsm #(.Lat(WRITE_LAT)) u_wr_fsm (
    .clk    (clk),
    .reset  (reset),
    .enable (write_enable),
    .finish (finish_write),
    .grant  (wr_grant),
    .req    (wr_req),
    .capture(wr_capture),
    .pulse  (wr_pulse)
  );

  // Single port: load beats read beats write; losers hold at cnt 0 and retry.
  assign rd_grant = rd_req && !load_en;
  assign wr_grant = wr_req && !load_en && !rd_req;

  assign rd_map = addr_to_index(rd_addr_q, BASE_ADDR, ADDR_WID);
  assign wr_map = addr_to_index(wr_addr_q, BASE_ADDR, ADDR_WID);
  assign rd_idx = ADDR_WID'(rd_map.idx);
  assign wr_idx = ADDR_WID'(wr_map.idx);

  always_ff @(posedge clk) begin
    if (load_en && load_we) begin
      mem_q[load_idx] <= load_data;
    end else if (wr_grant && !wr_map.oor) begin
      mem_q[wr_idx] <= wr_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      read_data_q <= '0;
      peek_data_q <= '0;
      rd_words_q  <= '0;
      wr_words_q  <= '0;
      perf_q      <= '0;
      armed_q     <= 1'b0;
      frozen_q    <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      if (rd_capture) rd_addr_q <= read_addr;
      if (wr_capture) begin
        wr_addr_q <= write_addr;
        wr_data_q <= write_data;
      end
      if (rd_grant) begin
        read_data_q <= rd_map.oor ? '0 : mem_q[rd_idx];
        rd_words_q  <= rd_words_q + 32'd1;
      end
      if (wr_grant) wr_words_q <= wr_words_q + 32'd1;
      if (load_en && !load_we) peek_data_q <= mem_q[load_idx];
      if ((rd_grant && rd_map.oor) || (wr_grant && wr_map.oor)) addr_err_q <= 1'b1;
      // The first read capture after reset is always an idle-to-wait transition.
      if (rd_capture && !armed_q) armed_q <= 1'b1;
      if (armed_q && !frozen_q) begin
        perf_q <= perf_q + 64'd1;
        if (done) frozen_q <= 1'b1;
      end
    end
  end

  assign read_ready  = {63'd0, rd_pulse};
  assign write_ready = {63'd0, wr_pulse};
  assign read_data   = read_data_q;
  assign peek_data   = peek_data_q;
  assign rd_words    = rd_words_q;
  assign wr_words    = wr_words_q;
  assign perf_cycles = perf_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_mem_stream_bridge.sv
// Scoreboard bench for mem_stream_bridge: directed scenarios plus randomized bursts,
// checked against an address-level memory model and expected pulse cycles.
module tb_mem_stream_bridge;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 32;
  localparam int unsigned RL    = 2;
  localparam int unsigned WL    = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [63:0] BASE  = 64'h1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_enable, finish_read, write_enable, finish_write, done;
  logic [63:0]   read_addr, write_addr;
  logic [DW-1:0] write_data, load_data;
  logic          load_en, load_we;
  logic [AW-1:0] load_idx;
  logic [63:0]   read_ready, write_ready, perf_cycles;
  logic [DW-1:0] read_data, peek_data;
  logic [31:0]   rd_words, wr_words;
  logic          addr_err;

  mem_stream_bridge #(
    .ADDR_WID (AW),
    .DATA_WID (DW),
    .BASE_ADDR(BASE),
    .READ_LAT (RL),
    .WRITE_LAT(WL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .read_enable (read_enable),
    .read_addr   (read_addr),
    .finish_read (finish_read),
    .read_ready  (read_ready),
    .read_data   (read_data),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .finish_write(finish_write),
    .write_ready (write_ready),
    .done        (done),
    .load_en     (load_en),
    .load_we     (load_we),
    .load_idx    (load_idx),
    .load_data   (load_data),
    .peek_data   (peek_data),
    .rd_words    (rd_words),
    .wr_words    (wr_words),
    .perf_cycles (perf_cycles),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            at;
  } rd_exp_t;

  rd_exp_t       rd_q[$];
  int            wr_q[$];
  rd_exp_t       rd_e;
  int            wr_e;
  logic [DW-1:0] mem_m [64];
  int            rd_cnt_m = 0, wr_cnt_m = 0;
  int            n_checks = 0, n_fail = 0;
  logic [63:0]   ra_list[$], wa_list[$];
  logic [DW-1:0] wd_list[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit oor_m(input logic [63:0] a);
    return (a < BASE) || (a % 4 != 0) || ((a - BASE) / 4 >= 64'(DEPTH));
  endfunction

  function automatic int idx_m(input logic [63:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [DW-1:0] rd_model(input logic [63:0] a);
    return oor_m(a) ? '0 : mem_m[idx_m(a)];
  endfunction

  function automatic void push_rd(input logic [63:0] a, input int at);
    rd_q.push_back('{data: rd_model(a), at: at});
    rd_cnt_m++;
  endfunction

  function automatic void push_wr(input logic [63:0] a, input logic [DW-1:0] d, input int at);
    if (!oor_m(a)) mem_m[idx_m(a)] = d;
    wr_q.push_back(at);
    wr_cnt_m++;
  endfunction

  // Monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      if (read_ready[0]) begin
        if (rd_q.size() == 0) check("rd_unexpected", read_ready, 64'd0);
        else begin
          rd_e = rd_q.pop_front();
          check("rd_data", 64'(read_data), 64'(rd_e.data));
          check("rd_cycle", 64'(cyc), 64'(rd_e.at));
        end
      end
      if (write_ready[0]) begin
        if (wr_q.size() == 0) check("wr_unexpected", write_ready, 64'd0);
        else begin
          wr_e = wr_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(wr_e));
        end
      end
    end
  end

  task automatic wait_pulse(input bit is_rd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_rd && read_ready[0]) return;
      if (!is_rd && write_ready[0]) return;
    end
    if (is_rd) check("rd_timeout", read_ready, 64'd1);
    else check("wr_timeout", write_ready, 64'd1);
  endtask

  task automatic read_burst();
    read_addr = ra_list[0];
    read_enable = 1'b1;
    push_rd(ra_list[0], cyc + 1 + int'(RL));
    for (int k = 0; k < ra_list.size(); k++) begin
      wait_pulse(1'b1);
      @(negedge clk);
      if (k + 1 < ra_list.size()) begin
        read_addr = ra_list[k+1];
        finish_read = 1'b1;
        push_rd(ra_list[k+1], cyc + 1 + int'(RL));
        @(negedge clk);
        finish_read = 1'b0;
      end
    end
    read_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_burst();
    write_addr = wa_list[0];
    write_data = wd_list[0];
    write_enable = 1'b1;
    push_wr(wa_list[0], wd_list[0], cyc + 1 + int'(WL));
    for (int k = 0; k < wa_list.size(); k++) begin
      wait_pulse(1'b0);
      @(negedge clk);
      if (k + 1 < wa_list.size()) begin
        write_addr = wa_list[k+1];
        write_data = wd_list[k+1];
        finish_write = 1'b1;
        push_wr(wa_list[k+1], wd_list[k+1], cyc + 1 + int'(WL));
        @(negedge clk);
        finish_write = 1'b0;
      end
    end
    write_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] d);
    load_idx = AW'(idx);
    load_data = d;
    load_we = 1'b1;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    load_we = 1'b0;
    mem_m[idx] = d;
  endtask

  task automatic peek_check(input int idx, input string name);
    load_idx = AW'(idx);
    load_we = 1'b0;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check(name, 64'(peek_data), 64'(mem_m[idx]));
  endtask

  // Read and write reach cnt 0 together; extra_load adds a peek on that cycle.
  task automatic contention(input bit extra_load);
    int c, rd_at, wr_at;
    logic [DW-1:0] d;
    c = cyc;
    d = $urandom;
    rd_at = c + 2 + int'(RL);
    wr_at = c + 1 + int'(WL);
    if (extra_load) begin
      rd_at++;
      wr_at++;
    end
    if (wr_at == rd_at) wr_at = rd_at + 1;
    write_addr = BASE + 20;
    write_data = d;
    write_enable = 1'b1;
    push_wr(BASE + 20, d, wr_at);
    @(negedge clk);
    read_addr = BASE + 16;
    read_enable = 1'b1;
    push_rd(BASE + 16, rd_at);
    @(negedge clk);
    @(negedge clk);
    if (extra_load) begin
      load_idx = '0;
      load_we = 1'b0;
      load_en = 1'b1;
    end
    @(negedge clk);
    load_en = 1'b0;
    if (extra_load) check("cont_peek", 64'(peek_data), 64'(mem_m[0]));
    repeat (5) @(negedge clk);
    read_enable = 1'b0;
    write_enable = 1'b0;
    @(negedge clk);
    check("cont_rd_drain", 64'(rd_q.size()), 64'd0);
    check("cont_wr_drain", 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b0;
    {read_enable, finish_read, write_enable, finish_write, done, load_en, load_we} = '0;
    read_addr = '0;
    write_addr = '0;
    write_data = '0;
    load_data = '0;
    load_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_read_ready", read_ready, 64'd0);
    check("rst_write_ready", write_ready, 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_counters", {rd_words, wr_words}, 64'd0);
    check("rst_perf", perf_cycles, 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) preload(i, (i < 4) ? DW'(10 + i) : DW'($urandom));

    // Streamed reads with finish_read handshakes
    ra_list = '{BASE, BASE + 4, BASE + 8, BASE + 12};
    read_burst();
    check("rd_words_4", 64'(rd_words), 64'(rd_cnt_m));

    // Write commit then peek
    wa_list = '{BASE + 8};
    wd_list = '{32'hA5};
    write_burst();
    peek_check(2, "peek_after_write");
    check("wr_words_1", 64'(wr_words), 64'(wr_cnt_m));

    contention(1'b0);
    contention(1'b1);

    // Out-of-range accesses
    check("addr_err_clear", 64'(addr_err), 64'd0);
    ra_list = '{BASE + 64'h10000, BASE - 4};
    read_burst();
    check("addr_err_set", 64'(addr_err), 64'd1);
    wa_list = '{BASE + 1};
    wd_list = '{32'hDEAD};
    write_burst();
    peek_check(0, "oor_write_dropped");
    peek_check(1, "oor_write_dropped1");
    check("rd_words_oor", 64'(rd_words), 64'(rd_cnt_m));

    // Abort in wait: no pulse expected
    read_addr = BASE;
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_rd_words", 64'(rd_words), 64'(rd_cnt_m));

    // Reset in the middle of a write
    write_addr = BASE + 24;
    write_data = ~mem_m[6];
    write_enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_outputs", {read_ready[0], write_ready[0], addr_err}, 64'd0);
    check("midrst_data", {read_data, peek_data}, 64'd0);
    check("midrst_counters", {rd_words, wr_words}, 64'd0);
    check("midrst_perf", perf_cycles, 64'd0);
    write_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd_cnt_m = 0;
    wr_cnt_m = 0;
    @(negedge clk);
    peek_check(6, "midrst_ram_kept");

    // Performance counter: arm on first read, freeze on done
    read_addr = BASE + 12;
    read_enable = 1'b1;
    t = cyc + 1;
    push_rd(BASE + 12, cyc + 1 + int'(RL));
    wait_pulse(1'b1);
    @(negedge clk);
    read_enable = 1'b0;
    while (cyc < t + 99) @(negedge clk);
    check("perf_running", perf_cycles, 64'd99);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("perf_frozen", perf_cycles, 64'd100);
    repeat (4) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    check("perf_second_done", perf_cycles, 64'd100);

    // Randomized bursts
    for (int it = 0; it < 16; it++) begin
      int n;
      bit is_rd;
      n = int'($urandom_range(1, 4));
      is_rd = $urandom_range(0, 1) == 1;
      ra_list.delete();
      wa_list.delete();
      wd_list.delete();
      for (int k = 0; k < n; k++) begin
        logic [63:0] a;
        case ($urandom_range(0, 9))
          0: a = BASE - 4 * 64'($urandom_range(1, 8));
          1: a = BASE + 4 * 64'($urandom_range(0, 63)) + 64'($urandom_range(1, 3));
          2: a = BASE + 4 * 64'(DEPTH) + 4 * 64'($urandom_range(0, 7));
          default: a = BASE + 4 * 64'($urandom_range(0, 63));
        endcase
        if (is_rd) ra_list.push_back(a);
        else begin
          wa_list.push_back(a);
          wd_list.push_back($urandom);
        end
      end
      if (is_rd) read_burst();
      else write_burst();
    end
    for (int i = 0; i < 64; i += 5) peek_check(i, "rand_peek");
    check("final_rd_words", 64'(rd_words), 64'(rd_cnt_m));
    check("final_wr_words", 64'(wr_words), 64'(wr_cnt_m));
    check("final_rd_drain", 64'(rd_q.size()), 64'd0);
    check("final_wr_drain", 64'(wr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
